// File: rtl/scan_chain_ctrl_pkg.sv
// ============================================================================
// Module      : scan_chain_ctrl_pkg
// Description : Shared types and helpers for the scan chain sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package scan_chain_ctrl_pkg;

    localparam int c_MIN_CHAIN_LEN = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        CAPTURE = 3'd2,
        UNLOAD  = 3'd3,
        DONE    = 3'd4
    } state_e;

    // Width needed to count 0 .. len-1, never narrower than one bit.
    function automatic int cnt_width(input int len);
        return (len <= 2) ? 1 : $clog2(len);
    endfunction

endpackage

`default_nettype wire

// File: rtl/scan_chain_ctrl_shreg.sv
// ============================================================================
// Module      : scan_chain_ctrl_shreg
// Description : Parallel-load, serial-in, serial-out (MSB) shift register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_chain_ctrl_shreg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_shift,
    input  logic             i_ser_in,
    output logic [WIDTH-1:0] o_par,
    output logic             o_ser_out
);

    logic [WIDTH-1:0] r_data_q;
    logic [WIDTH-1:0] w_data_d;

    // Load has priority over shift.
    always_comb begin
        w_data_d = r_data_q;
        if (i_load) begin
            w_data_d = i_load_val;
        end else if (i_shift) begin
            w_data_d = {r_data_q[WIDTH-2:0], i_ser_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_data_q <= '0;
        end else begin
            r_data_q <= w_data_d;
        end
    end

    assign o_par     = r_data_q;
    assign o_ser_out = r_data_q[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/scan_chain_ctrl.sv
// ============================================================================
// Module      : scan_chain_ctrl
// Description : Load / capture / unload sequencer for one mux-scan chain.
//               Optional compare logic enabled by SCAN_CHAIN_CTRL_COMPARE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_chain_ctrl
    import scan_chain_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 32,
    parameter int CNT_W     = cnt_width(CHAIN_LEN)
) (
    input  logic                 CLK,
    input  logic                 RN,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic                 scan_so,
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic [CHAIN_LEN-1:0] mask,
    output logic                 mismatch,
`endif
    output logic                 scan_se,
    output logic                 scan_si,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] response
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    generate
        if (CHAIN_LEN < c_MIN_CHAIN_LEN) begin : g_len_check
            $error("scan_chain_ctrl: CHAIN_LEN below minimum");
        end
    endgenerate

    state_e           r_state_q, w_state_d;
    logic [CNT_W-1:0] r_cnt_q, w_cnt_d;
    logic             r_se_q, w_se_d;
    logic             r_busy_q, w_busy_d;
    logic             r_done_q, w_done_d;
    logic             w_accept;
    logic             w_pat_msb;
    logic [CHAIN_LEN-1:0] w_pat_unused;
    logic             w_resp_msb_unused;

    always_comb begin
        w_state_d = r_state_q;
        w_accept  = 1'b0;
        case (r_state_q)
            IDLE: begin
                if (start) begin
                    w_state_d = LOAD;
                    w_accept  = 1'b1;
                end
            end
            LOAD:    if (r_cnt_q == c_CNT_LAST) w_state_d = CAPTURE;
            CAPTURE: w_state_d = UNLOAD;
            UNLOAD:  if (r_cnt_q == c_CNT_LAST) w_state_d = DONE;
            DONE: begin
                // A held start chains straight into the next load.
                if (start) begin
                    w_state_d = LOAD;
                    w_accept  = 1'b1;
                end else begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase

        w_cnt_d = '0;
        if ((w_state_d == r_state_q) && ((r_state_q == LOAD) || (r_state_q == UNLOAD))) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end

        w_se_d   = (w_state_d == LOAD) || (w_state_d == UNLOAD);
        w_busy_d = (w_state_d != IDLE);
        w_done_d = (w_state_d == DONE);
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            r_state_q <= IDLE;
            r_cnt_q   <= '0;
            r_se_q    <= 1'b0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_se_q    <= w_se_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
        end
    end

    // Serializer shifts in zeros, so its MSB is already 0 once LOAD has
    // drained it; that flop drives scan_si directly.
    scan_chain_ctrl_shreg #(
        .WIDTH (CHAIN_LEN)
    ) u_pat_ser (
        .clk        (CLK),
        .i_rst_n    (RN),
        .i_load     (w_accept),
        .i_load_val (pattern),
        .i_shift    (r_state_q == LOAD),
        .i_ser_in   (1'b0),
        .o_par      (w_pat_unused),
        .o_ser_out  (w_pat_msb)
    );

    scan_chain_ctrl_shreg #(
        .WIDTH (CHAIN_LEN)
    ) u_resp_des (
        .clk        (CLK),
        .i_rst_n    (RN),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_shift    (r_state_q == UNLOAD),
        .i_ser_in   (scan_so),
        .o_par      (response),
        .o_ser_out  (w_resp_msb_unused)
    );

    assign scan_se = r_se_q;
    assign scan_si = w_pat_msb;
    assign busy    = r_busy_q;
    assign done    = r_done_q;

`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    logic [CHAIN_LEN-1:0] r_exp_q, w_exp_d;
    logic [CHAIN_LEN-1:0] r_mask_q, w_mask_d;
    logic                 r_mismatch_q, w_mismatch_d;

    always_comb begin
        w_exp_d      = r_exp_q;
        w_mask_d     = r_mask_q;
        w_mismatch_d = r_mismatch_q;
        if (w_accept) begin
            w_exp_d      = expected;
            w_mask_d     = mask;
            w_mismatch_d = 1'b0;
        end else if ((r_state_q == UNLOAD) && (w_state_d == DONE)) begin
            // Fold in the final serial bit arriving on this same edge.
            w_mismatch_d = |(({response[CHAIN_LEN-2:0], scan_so} ^ r_exp_q) & r_mask_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            r_exp_q      <= '0;
            r_mask_q     <= '0;
            r_mismatch_q <= 1'b0;
        end else begin
            r_exp_q      <= w_exp_d;
            r_mask_q     <= w_mask_d;
            r_mismatch_q <= w_mismatch_d;
        end
    end

    assign mismatch = r_mismatch_q;
`endif

endmodule

`default_nettype wire
